// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit-ISA CPU: FETCH/DECODE/EXEC/MEM/WB over one shared, stallable req/ready memory port.
// Optional HALT state enabled by defining MULTICYCLE_CPU_HALT_EN; otherwise opcode 1111 is a NOP.
`timescale 1ns/1ps
module multicycle_cpu #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic              wb_valid,
   output logic [1:0]        wb_reg,
   output logic [DATA_W-1:0] wb_data,
   output logic              halted
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_ADDI = 4'b0100;
   localparam logic [3:0] OP_LW   = 4'b0101;
   localparam logic [3:0] OP_SW   = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_BNE  = 4'b1001;
`ifdef MULTICYCLE_CPU_HALT_EN
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
`else
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
`endif

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       ir_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] res_q;
   logic [1:0]        dst_q;
   logic [DATA_W-1:0] rf_q [4];

   logic [3:0]        op;
   logic [1:0]        rs;
   logic [1:0]        rt;
   logic [1:0]        rd;
   logic signed [7:0] imm8;
   logic [DATA_W-1:0] imm_d;
   logic [DATA_W-1:0] sum_d;
   logic [DATA_W-1:0] alu_d;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [ADDR_W-1:0] imm_a;
   logic [ADDR_W-1:0] ea_d;
   logic [ADDR_W-1:0] br_tgt;

   assign op     = ir_q[15:12];
   assign rs     = ir_q[11:10];
   assign rt     = ir_q[9:8];
   assign rd     = ir_q[7:6];
   assign imm8   = ir_q[7:0];
   // Size casts of a signed operand sign-extend, giving sext(imm) at either width.
   assign imm_d  = DATA_W'(imm8);
   assign imm_a  = ADDR_W'(imm8);
   assign sum_d  = a_q + imm_d;
   assign ea_d   = ADDR_W'(sum_d);
   assign br_tgt = pc_q + imm_a;
   assign rs_val = (rs == 2'd0) ? '0 : rf_q[rs];
   assign rt_val = (rt == 2'd0) ? '0 : rf_q[rt];

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      alu_d = '0;
      case (op)
         OP_ADD:  alu_d = a_q + b_q;
         OP_SUB:  alu_d = a_q - b_q;
         OP_AND:  alu_d = a_q & b_q;
         OP_OR:   alu_d = a_q | b_q;
         OP_SLT:  alu_d = DATA_W'($signed(a_q) < $signed(b_q));
         OP_ADDI: alu_d = sum_d;
         default: alu_d = '0;
      endcase
   end

   // The port is driven straight from state so the first fetch is requested right after reset release;
   // address and data come from registers that do not move while a transaction is outstanding.
   assign mem_req   = reset_n && (state_q == S_FETCH || state_q == S_MEM);
   assign mem_we    = (state_q == S_MEM) && (op == OP_SW);
   assign mem_addr  = (state_q == S_MEM) ? addr_q : pc_q;
   assign mem_wdata = b_q;
   assign pc        = pc_q;
   assign wb_valid  = (state_q == S_WB) && (dst_q != 2'd0);
   assign wb_reg    = dst_q;
   assign wb_data   = res_q;
`ifdef MULTICYCLE_CPU_HALT_EN
   assign halted    = (state_q == S_HALT);
`else
   assign halted    = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         addr_q  <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         dst_q   <= 2'd0;
         // NOTE: the register file is only four words and must come up zeroed, so it is reset like any flop.
         for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_ready) begin
                  ir_q    <= mem_rdata[15:0];
                  pc_q    <= pc_q + ADDR_W'(1);
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q     <= rs_val;
               b_q     <= rt_val;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               case (op)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                     res_q   <= alu_d;
                     dst_q   <= rd;
                     state_q <= S_WB;
                  end
                  OP_ADDI: begin
                     res_q   <= alu_d;
                     dst_q   <= rt;
                     state_q <= S_WB;
                  end
                  OP_LW, OP_SW: begin
                     addr_q  <= ea_d;
                     dst_q   <= rt;
                     state_q <= S_MEM;
                  end
                  OP_BEQ: begin
                     if (a_q == b_q) pc_q <= br_tgt;
                     state_q <= S_FETCH;
                  end
                  OP_BNE: begin
                     if (a_q != b_q) pc_q <= br_tgt;
                     state_q <= S_FETCH;
                  end
`ifdef MULTICYCLE_CPU_HALT_EN
                  OP_HALT: state_q <= S_HALT;
`endif
                  default: state_q <= S_FETCH;
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (op == OP_SW) begin
                     state_q <= S_FETCH;
                  end else begin
                     res_q   <= mem_rdata;
                     state_q <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (dst_q != 2'd0) rf_q[dst_q] <= res_q;
               state_q <= S_FETCH;
            end
`ifdef MULTICYCLE_CPU_HALT_EN
            S_HALT: state_q <= S_HALT;
`endif
            default: state_q <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: expected writebacks are queued by the stimulus and
// popped by a negedge monitor; memory, fetch addresses and port stability are checked alongside.
`timescale 1ns/1ps
module tb_multicycle_cpu;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_ADDI = 4'b0100;
   localparam logic [3:0] OP_LW   = 4'b0101;
   localparam logic [3:0] OP_SW   = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_BNE  = 4'b1001;

   typedef struct {
      logic [1:0]  r;
      logic [15:0] d;
      int          gap;
   } wb_t;

   logic              clock = 1'b0;
   logic              reset_n = 1'b1;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] pc;
   logic              wb_valid;
   logic [1:0]        wb_reg;
   logic [DATA_W-1:0] wb_data;
   logic              halted;

   logic [15:0] mem [256];
   wb_t         sb_q[$];
   logic [15:0] fetch_log[$];
   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   int          last_wb_cyc = 0;
   int          stall_mode = 0;
   int          wait_left = 0;
   bit          in_txn = 0;
   bit          completed = 0;
   logic [ADDR_W-1:0] s_addr;
   logic              s_we;
   logic [DATA_W-1:0] s_wdata;

   assign mem_rdata = mem[mem_addr[7:0]];

   multicycle_cpu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .pc        (pc),
      .wb_valid  (wb_valid),
      .wb_reg    (wb_reg),
      .wb_data   (wb_data),
      .halted    (halted)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs, input logic [1:0] rt);
      return {op, rs, rt, rd, 6'b000000};
   endfunction

   function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [1:0] rt,
                                         input logic [1:0] rs, input logic [7:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_wb(input logic [1:0] r, input logic [15:0] d, input int gap);
      wb_t e;
      e.r   = r;
      e.d   = d;
      e.gap = gap;
      sb_q.push_back(e);
   endtask

   task automatic check_fetch(input string name, input int idx, input logic [15:0] exp);
      check(name, (idx < fetch_log.size()) ? {16'h0, fetch_log[idx]} : 32'hDEAD_BEEF, {16'h0, exp});
   endtask

   task automatic hold_reset();
      reset_n   = 1'b0;
      mem_ready = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      fetch_log.delete();
      sb_q.delete();
   endtask

   task automatic release_reset(input int mode);
      stall_mode = mode;
      @(negedge clock);
      #2 reset_n = 1'b1;
   endtask

   task automatic run(input int n, input string name);
      repeat (n) @(negedge clock);
      check(name, sb_q.size(), 0);
   endtask

   // Memory model: writes commit only on a completing edge with reset released.
   always @(posedge clock) begin
      cyc++;
      completed = reset_n && mem_req && mem_ready;
      if (completed) begin
         if (mem_we) mem[mem_addr[7:0]] = mem_wdata[15:0];
         else if (mem_addr == pc) fetch_log.push_back(mem_addr);
      end
   end

   // Monitor: scoreboard pop on writeback, port stability during stalls, ready generation.
   always @(negedge clock) begin
      if (wb_valid) begin
         compared++;
         if (sb_q.size() == 0) begin
            mismatched++;
            $display("FAIL wb_unexpected: got r%0d=%0h expected no writeback", wb_reg, wb_data);
         end else begin
            wb_t e;
            e = sb_q.pop_front();
            if (wb_reg !== e.r || wb_data !== e.d || (e.gap != 0 && cyc - last_wb_cyc != e.gap)) begin
               mismatched++;
               $display("FAIL wb: got r%0d=%0h gap %0d expected r%0d=%0h gap %0d",
                        wb_reg, wb_data, cyc - last_wb_cyc, e.r, e.d, e.gap);
            end
         end
         last_wb_cyc = cyc;
      end
      if (!reset_n || !mem_req) begin
         in_txn    = 0;
         wait_left = 0;
      end else begin
         if (in_txn && !completed) begin
            check("stall_stable", {mem_addr, s_we, s_wdata[14:0]}, {s_addr, s_we, s_wdata[14:0]});
            compared++;
            if (mem_we !== s_we || mem_wdata !== s_wdata) begin
               mismatched++;
               $display("FAIL stall_we_data: got we=%0b wd=%0h expected we=%0b wd=%0h",
                        mem_we, mem_wdata, s_we, s_wdata);
            end
            if (wait_left > 0) wait_left--;
         end else begin
            in_txn    = 1;
            wait_left = (stall_mode == 1) ? int'($urandom_range(0, 3)) : 0;
         end
         s_addr  = mem_addr;
         s_we    = mem_we;
         s_wdata = mem_wdata;
      end
      mem_ready = (stall_mode == 2) ? !mem_we : (wait_left == 0);
   end

   task automatic load_swap();
      mem[20] = 16'd5;
      mem[21] = 16'd7;
      mem[0]  = enc_i(OP_LW, 2'd1, 2'd0, 8'd20);
      mem[1]  = enc_i(OP_LW, 2'd2, 2'd0, 8'd21);
      mem[2]  = enc_r(OP_SLT, 2'd3, 2'd1, 2'd2);
      mem[3]  = enc_i(OP_BEQ, 2'd0, 2'd3, 8'd2);
      mem[4]  = enc_i(OP_SW, 2'd1, 2'd0, 8'd21);
      mem[5]  = enc_i(OP_SW, 2'd2, 2'd0, 8'd20);
      mem[6]  = enc_i(OP_BEQ, 2'd0, 2'd0, 8'hFF);
   endtask

   initial begin
      bit found;
      mem_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      #1 reset_n = 1'b0;
      #1;
      check("rst mem_req", mem_req, 0);
      check("rst mem_we", mem_we, 0);
      check("rst mem_addr", mem_addr, 0);
      check("rst mem_wdata", mem_wdata, 0);
      check("rst pc", pc, 0);
      check("rst wb_valid", wb_valid, 0);
      check("rst wb_reg", wb_reg, 0);
      check("rst wb_data", wb_data, 0);
      check("rst halted", halted, 0);

      // ALU program, zero-wait memory, writebacks 4 cycles apart.
      hold_reset();
      mem[0] = enc_i(OP_ADDI, 2'd1, 2'd0, 8'd15);
      mem[1] = enc_i(OP_ADDI, 2'd2, 2'd0, 8'd7);
      mem[2] = enc_r(OP_AND, 2'd3, 2'd1, 2'd2);
      mem[3] = enc_r(OP_SUB, 2'd2, 2'd1, 2'd3);
      mem[4] = enc_r(OP_OR,  2'd2, 2'd2, 2'd3);
      mem[5] = enc_r(OP_ADD, 2'd3, 2'd2, 2'd3);
      mem[6] = enc_r(OP_SLT, 2'd1, 2'd3, 2'd2);
      mem[7] = enc_r(OP_SLT, 2'd1, 2'd2, 2'd3);
      mem[8] = enc_i(OP_BEQ, 2'd0, 2'd0, 8'hFF);
      expect_wb(2'd1, 16'd15, 0);
      expect_wb(2'd2, 16'd7,  4);
      expect_wb(2'd3, 16'd7,  4);
      expect_wb(2'd2, 16'd8,  4);
      expect_wb(2'd2, 16'd15, 4);
      expect_wb(2'd3, 16'd22, 4);
      expect_wb(2'd1, 16'd0,  4);
      expect_wb(2'd1, 16'd1,  4);
      release_reset(0);
      run(60, "alu drained");

      // Load/compare/store swap, zero-wait: LW takes 5 cycles, SLT 4.
      hold_reset();
      load_swap();
      expect_wb(2'd1, 16'd5, 0);
      expect_wb(2'd2, 16'd7, 5);
      expect_wb(2'd3, 16'd1, 4);
      release_reset(0);
      run(60, "swap drained");
      check("swap mem20", mem[20], 16'd7);
      check("swap mem21", mem[21], 16'd5);

      // Same swap with random wait states.
      hold_reset();
      load_swap();
      expect_wb(2'd1, 16'd5, 0);
      expect_wb(2'd2, 16'd7, 0);
      expect_wb(2'd3, 16'd1, 0);
      release_reset(1);
      run(200, "stall swap drained");
      check("stall swap mem20", mem[20], 16'd7);
      check("stall swap mem21", mem[21], 16'd5);

      // BEQ not taken, write to R0 discarded, BNE self-loop.
      hold_reset();
      mem[0] = enc_i(OP_ADDI, 2'd1, 2'd0, 8'd3);
      mem[1] = enc_i(OP_BEQ, 2'd0, 2'd1, 8'd5);
      mem[2] = enc_i(OP_ADDI, 2'd0, 2'd0, 8'd5);
      mem[3] = enc_i(OP_BNE, 2'd0, 2'd1, 8'hFF);
      expect_wb(2'd1, 16'd3, 0);
      release_reset(0);
      run(50, "loop drained");
      check_fetch("beq fall-through", 2, 16'd2);
      check_fetch("after r0 write", 3, 16'd3);
      check_fetch("bne loop a", 4, 16'd3);
      check_fetch("bne loop b", 5, 16'd3);
      check_fetch("bne loop c", 6, 16'd3);

      // Branch target wrapping below address 0 and back across it.
      hold_reset();
      mem[0]   = 16'hA000;
      mem[1]   = enc_i(OP_BEQ, 2'd0, 2'd0, 8'hFD);
      mem[255] = enc_i(OP_BEQ, 2'd0, 2'd0, 8'hFF);
      release_reset(0);
      run(40, "wrap drained");
      check_fetch("wrap f1", 1, 16'd1);
      check_fetch("wrap f2", 2, 16'hFFFF);
      check_fetch("wrap f3", 3, 16'hFFFF);
      check_fetch("wrap f4", 4, 16'hFFFF);

      // Opcode 1111: halts when enabled, otherwise a 3-cycle NOP.
      hold_reset();
      mem[0] = enc_i(OP_ADDI, 2'd1, 2'd0, 8'd1);
      mem[1] = 16'hF000;
      mem[2] = enc_i(OP_ADDI, 2'd2, 2'd0, 8'd2);
      mem[3] = enc_i(OP_BEQ, 2'd0, 2'd0, 8'hFF);
      expect_wb(2'd1, 16'd1, 0);
`ifndef MULTICYCLE_CPU_HALT_EN
      expect_wb(2'd2, 16'd2, 7);
`endif
      release_reset(0);
      run(40, "halt drained");
`ifdef MULTICYCLE_CPU_HALT_EN
      for (int i = 0; i < 4; i++) begin
         check("halted", halted, 1);
         check("halt no req", mem_req, 0);
         repeat (5) @(negedge clock);
      end
      check("halt pc", pc, 16'd2);
`else
      check("halted off", halted, 0);
      check_fetch("nop continue", 2, 16'd2);
`endif

      // Reset during a stalled store: nothing written, restart from address 0.
      hold_reset();
      mem[0]  = enc_i(OP_ADDI, 2'd1, 2'd0, 8'd9);
      mem[1]  = enc_i(OP_SW, 2'd1, 2'd0, 8'd30);
      mem[2]  = enc_i(OP_BEQ, 2'd0, 2'd0, 8'hFF);
      mem[30] = 16'h1234;
      expect_wb(2'd1, 16'd9, 0);
      release_reset(2);
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clock);
         found = mem_req && mem_we;
      end
      check("store reached", found, 1);
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("mid rst mem_req", mem_req, 0);
      check("mid rst pc", pc, 0);
      @(negedge clock);
      check("mid rst no write", mem[30], 16'h1234);
      stall_mode = 0;
      expect_wb(2'd1, 16'd9, 0);
      #2 reset_n = 1'b1;
      #1;
      check("restart req", mem_req, 1);
      check("restart addr", mem_addr, 0);
      check("restart we", mem_we, 0);
      run(40, "restart drained");
      check("restart store", mem[30], 16'd9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle 16-bit CPU. Executes the same 16-bit instruction encoding over an FSM (fetch/decode/execute/memory/writeback), with datapath width and address width as parameters. A single shared, stallable memory port with a req/ready handshake carries both instruction fetch and load/store traffic. Adds BNE, HALT, reset and a writeback observation port.

## Interface
- `DATA_W`, default 16: register, ALU and memory data width; must be ≥16.
- `ADDR_W`, default 16: word-address width of the memory port and PC.
- `clock` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_req` out 1: memory transaction request.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out DATA_W: store data.
- `mem_ready` in 1: transaction completes at the posedge where `mem_req && mem_ready`.
- `mem_rdata` in DATA_W: read data, sampled at completion; fetch uses `[15:0]`.
- `pc` out ADDR_W: current PC.
- `wb_valid` out 1: one-cycle pulse when a register is written.
- `wb_reg` out 2: destination register of that write.
- `wb_data` out DATA_W: data written.
- `halted` out 1: core stopped in HALT.

## Operation
- Instruction fields: op=[15:12], rs=[11:10], rt=[9:8], rd=[7:6], imm=[7:0].
- imm is sign-extended to DATA_W for ALU use and to ADDR_W for address use.
- Register file: 4 × DATA_W registers, reset to 0. R0 reads 0 always; writes to R0 are discarded and produce no `wb_valid`.
- Opcodes:
  - 0000 ADD rd=rs+rt
  - 0001 SUB rd=rs−rt
  - 0010 AND rd=rs&rt
  - 0011 OR rd=rs|rt
  - 0111 SLT rd=(signed rs<rt)?1:0
  - 0100 ADDI rt=rs+imm
  - 0101 LW rt=mem[rs+imm]
  - 0110 SW mem[rs+imm]=rt
  - 1000 BEQ: if rs==rt, PC=PC+1+imm
  - 1001 BNE: if rs!=rt, PC=PC+1+imm
  - 1111 HALT
  - All others: NOP.
- Arithmetic wraps modulo 2^DATA_W. Effective address = low ADDR_W bits of (rs + sext imm). PC arithmetic wraps modulo 2^ADDR_W.
- FSM states and transitions:
  - FETCH: `mem_req=1`, `we=0`, `addr=PC`. On completion: latch IR, PC←PC+1, go to DECODE.
  - DECODE: latch A=rs, B=rt. Go to EXEC.
  - EXEC:
    - ALU ops → WB.
    - LW/SW: latch address → MEM.
    - BEQ/BNE: update PC if taken → FETCH.
    - NOP → FETCH.
    - HALT → HALT.
  - MEM: `mem_req=1`, `we`=(SW), `wdata`=B. On completion: LW latches data → WB; SW → FETCH.
  - WB: write register, pulse `wb_valid`. Go to FETCH.
  - HALT: `mem_req=0`, `halted=1`. Left only by reset.
- Handshake rules:
  - `mem_addr`, `mem_we` and `mem_wdata` are held stable from `mem_req` rise until completion.
  - `mem_ready` is ignored while `mem_req=0`.
  - Wait states are unbounded; the FSM stays in its state.

## Timing
- Reset values: `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `pc=0`, `wb_valid=0`, `wb_reg=0`, `wb_data=0`, `halted=0`; state=FETCH.
- `mem_req` is gated low while `reset_n=0`. The first fetch request is in the first cycle after release.
- Cycles with zero-wait memory (`mem_ready` tied 1):
  - R-type/ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ/BNE/NOP: 3
- Each memory wait cycle adds one cycle to the instruction.
- `wb_valid` is high for exactly the WB cycle. The register value is visible to the next instruction's DECODE.
- Reset asserted mid-transaction: the transaction is abandoned and no register write occurs. The external write is committed only if completion coincides with a posedge while `reset_n=1`.
- Branch with offset −1 loops on itself. Branch target wraps across address 0.

## Configuration
- `MULTICYCLE_CPU_HALT_EN`:
  - Defined: opcode 1111 enters HALT as above.
  - Undefined: 1111 executes as NOP, the HALT state is absent and `halted` is tied 0.

## Test plan
- Zero-wait program `ADDI R1,R0,15; ADDI R2,R0,7; AND R3,R1,R2; SUB R2,R1,R3; OR R2,R2,R3; ADD R3,R2,R3; SLT R1,R3,R2; SLT R1,R2,R3` → `wb` sequence (1,15),(2,7),(3,7),(2,8),(2,15),(3,22),(1,0),(1,1), each 4 cycles apart.
- mem[20]=5, mem[21]=7; `LW R1,20(R0); LW R2,21(R0); SLT R3,R1,R2; BEQ R3,R0,+2; SW R1,21(R0); SW R2,20(R0)` → mem[20]=7, mem[21]=5.
- Same program with `mem_ready` randomly low 0–3 cycles → same final memory. Address and data stay stable during every stall.
- `BNE R1,R0,-1` with R1=3 → loops at the same PC. `BEQ` not taken → PC+1. `ADDI R0,R0,5` → no `wb_valid`.
- HALT (macro on) → `halted=1` and `mem_req=0` forever. Macro off → execution continues at the next word.
- `reset_n` pulsed low during a stalled SW → no write, `pc=0`, and the first fetch starts from address 0.
